// File: rtl/instruction_fetch.sv
// instruction_fetch: single-stage fetch with stall/redirect handling and a sticky fault on illegal addresses.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_1000,
    parameter logic [19:0] IMEM_REGION = 20'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_data_in,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);
    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
    state_t state, state_next;
    logic [31:0] fetch_pc, req_pc, issue_pc;
    logic req_valid, legal, advance;
    always_comb begin
        issue_pc   = state == BOOT  ? fetch_pc :
                     state == FAULT ? req_pc :
                     redirect_valid ? redirect_pc :
                     stall          ? req_pc : fetch_pc;
        legal      = issue_pc[31:12] == IMEM_REGION && issue_pc[1:0] == 2'b00;
        // A held (stalled) address was already checked when first issued
        advance    = state == BOOT || (state == RUN && (redirect_valid || !stall));
        state_next = state == BOOT ? RUN :
                     (state == RUN && advance && !legal) ? FAULT : state;
    end
    assign imem_address = issue_pc;
    assign if_instr     = imem_data_in;
    assign if_pc        = req_pc;
    assign if_valid     = req_valid && state == RUN && !redirect_valid;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            req_pc      <= RESET_PC;
            req_valid   <= 1'b0;
            fault       <= 1'b0;
            fault_pc    <= '0;
            fetch_count <= '0;
        end else begin
            state <= state_next;
            if (advance) begin
                if (state == RUN && !legal) begin
                    fault     <= 1'b1;
                    fault_pc  <= issue_pc;
                    req_valid <= 1'b0;
                end else begin
                    req_pc    <= issue_pc;
                    req_valid <= 1'b1;
                    fetch_pc  <= issue_pc + 32'd4;
                end
            end
            if (if_valid && !stall)
                fetch_count <= fetch_count + 32'd1;
        end
    end
endmodule
